// File: rtl/inv_shiftrows_seq.sv
// Sequential AES InvShiftRows stage for the inverse cipher datapath.
// A 128-bit state is captured on an accepted start, then its rows are
// rotated right (row r by r bytes), ROWS_PER_CYCLE rows per clock. The
// finished state is registered on state_out_o together with a one-cycle
// done_o pulse.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset
//   start_i      capture request, honoured in idle and done states only
//   state_in_i   input state, byte bN = [127-8N -: 8], bN = row N%4, col N/4
//   busy_o       high while rows are being permuted; start_i ignored
//   done_o       one-cycle pulse when state_out_o carries a new result
//   state_out_o  registered InvShiftRows result, same byte ordering
module inv_shiftrows_seq #(
  parameter int unsigned ROWS_PER_CYCLE = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [127:0] state_in_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [127:0] state_out_o
);

  if (ROWS_PER_CYCLE != 1 && ROWS_PER_CYCLE != 2 && ROWS_PER_CYCLE != 4) begin : g_bad_rpc
    $error("inv_shiftrows_seq: ROWS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [2:0] RowStep = 3'(ROWS_PER_CYCLE);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e       state_q, state_d;
  logic [127:0] work_q, work_d;
  logic [1:0]   row_cnt_q, row_cnt_d;
  logic [127:0] state_out_q, state_out_d;

  // One past the last row handled this cycle; bit 2 set means row 3 is included.
  logic [2:0]   row_end;
  logic         last_rows;
  logic [127:0] shifted;

  assign row_end   = {1'b0, row_cnt_q} + RowStep;
  assign last_rows = row_end[2];

  // Rotate the selected rows right by their row index; other rows pass through.
  always_comb begin
    shifted = work_q;
    for (int r = 0; r < 4; r++) begin
      if (r >= int'(row_cnt_q) && r < int'(row_end)) begin
        for (int c = 0; c < 4; c++) begin
          shifted[127 - 8 * (4 * c + r) -: 8] = work_q[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
        end
      end
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      work_q      <= '0;
      row_cnt_q   <= '0;
      state_out_q <= '0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      row_cnt_q   <= row_cnt_d;
      state_out_q <= state_out_d;
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    row_cnt_d   = row_cnt_q;
    state_out_d = state_out_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d   = StShift;
          work_d    = state_in_i;
          row_cnt_d = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        work_d = shifted;
        if (last_rows) begin
          state_out_d = shifted;
          row_cnt_d   = '0;
          state_d     = StDone;
        end else begin
          row_cnt_d = row_end[1:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    busy_o = (state_q == StShift);
    done_o = (state_q == StDone);
  end

  assign state_out_o = state_out_q;

endmodule

// File: tb/tb_inv_shiftrows_seq.sv
// Self-checking bench for inv_shiftrows_seq. Three instances (1, 2 and 4
// rows per cycle) share one stimulus stream; each is tracked by a
// transaction-level model (countdown of remaining cycles + row rotation).
module tb_inv_shiftrows_seq;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] state_in;
  logic [2:0]   busy_w;
  logic [2:0]   done_w;
  logic [127:0] sout_w [3];

  int checks = 0;
  int errors = 0;

  // Reference model per instance.
  int           m_rem  [3];
  logic         m_done [3];
  logic [127:0] m_out  [3];
  logic [127:0] m_cap  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inv_shiftrows_seq #(.ROWS_PER_CYCLE(1 << g)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .state_in_i  (state_in),
      .busy_o      (busy_w[g]),
      .done_o      (done_w[g]),
      .state_out_o (sout_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Arrange as a 4x4 matrix, rotate row r right by r, flatten back.
  function automatic logic [127:0] ref_inv(input logic [127:0] s);
    logic [7:0]   row [4][4];
    logic [7:0]   rot [4][4];
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) row[r][c] = s[127 - 8 * (4 * c + r) -: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) rot[r][(c + r) % 4] = row[r][c];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[127 - 8 * (4 * c + r) -: 8] = rot[r][c];
    return o;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_rem[k] = 0; m_done[k] = 1'b0; m_out[k] = '0; m_cap[k] = '0;
    end
  endtask

  // Advance model with the inputs the DUT will sample, then clock once.
  task automatic step();
    for (int k = 0; k < 3; k++) begin
      if (!rst) begin
        if (m_rem[k] != 0) begin
          m_rem[k]--;
          m_done[k] = (m_rem[k] == 0);
          if (m_rem[k] == 0) m_out[k] = ref_inv(m_cap[k]);
        end else begin
          m_done[k] = 1'b0;
          if (start) begin
            m_cap[k] = state_in;
            m_rem[k] = 4 >> k;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      checks += 3;
      if (busy_w[k] !== 1'b0) begin
        errors++; $display("FAIL reset busy rpc%0d: got %b want 0", 1 << k, busy_w[k]);
      end
      if (done_w[k] !== 1'b0) begin
        errors++; $display("FAIL reset done rpc%0d: got %b want 0", 1 << k, done_w[k]);
      end
      if (sout_w[k] !== 128'h0) begin
        errors++; $display("FAIL reset state_out rpc%0d: got %h want 0", 1 << k, sout_w[k]);
      end
    end
  endtask

  // Single op with a fixed vector; state_in scrambled after capture.
  task automatic test_fixed(input string name, input logic [127:0] vin, input logic [127:0] want);
    for (int i = 0; i < 7; i++) begin
      start    = (i == 0);
      state_in = (i == 0) ? vin : rand128();
      step();
      for (int k = 0; k < 3; k++) begin
        checks += 3;
        if (busy_w[k] !== (m_rem[k] != 0)) begin
          errors++; $display("FAIL %s busy rpc%0d cyc%0d: got %b want %b", name, 1 << k, i,
                             busy_w[k], m_rem[k] != 0);
        end
        if (done_w[k] !== m_done[k]) begin
          errors++; $display("FAIL %s done rpc%0d cyc%0d: got %b want %b", name, 1 << k, i,
                             done_w[k], m_done[k]);
        end
        if (sout_w[k] !== m_out[k]) begin
          errors++; $display("FAIL %s state_out rpc%0d cyc%0d: got %h want %h", name, 1 << k, i,
                             sout_w[k], m_out[k]);
        end
      end
    end
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (sout_w[k] !== want) begin
        errors++; $display("FAIL %s const rpc%0d: got %h want %h", name, 1 << k, sout_w[k], want);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [127:0] a;
    int           pulses;
    a      = rand128();
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      start    = (i <= 2);
      state_in = (i == 0) ? a : rand128();
      step();
      if (done_w[0]) pulses++;
      for (int k = 0; k < 3; k++) begin
        checks += 3;
        if (busy_w[k] !== (m_rem[k] != 0)) begin
          errors++; $display("FAIL busy_ignore busy rpc%0d cyc%0d: got %b want %b", 1 << k, i,
                             busy_w[k], m_rem[k] != 0);
        end
        if (done_w[k] !== m_done[k]) begin
          errors++; $display("FAIL busy_ignore done rpc%0d cyc%0d: got %b want %b", 1 << k, i,
                             done_w[k], m_done[k]);
        end
        if (sout_w[k] !== m_out[k]) begin
          errors++; $display("FAIL busy_ignore state_out rpc%0d cyc%0d: got %h want %h", 1 << k,
                             i, sout_w[k], m_out[k]);
        end
      end
    end
    start = 1'b0;
    checks += 2;
    if (pulses !== 1) begin
      errors++; $display("FAIL busy_ignore pulses rpc1: got %0d want 1", pulses);
    end
    if (sout_w[0] !== ref_inv(a)) begin
      errors++; $display("FAIL busy_ignore result rpc1: got %h want %h", sout_w[0], ref_inv(a));
    end
  endtask

  task automatic test_back_to_back();
    int last_done;
    last_done = -1;
    for (int i = 0; i < 22; i++) begin
      start    = (i < 15);
      state_in = rand128();
      step();
      if (done_w[0]) begin
        if (last_done >= 0) begin
          checks++;
          if (i - last_done != 5) begin
            errors++; $display("FAIL b2b spacing rpc1: got %0d want 5", i - last_done);
          end
        end
        last_done = i;
      end
      for (int k = 0; k < 3; k++) begin
        checks += 3;
        if (busy_w[k] !== (m_rem[k] != 0)) begin
          errors++; $display("FAIL b2b busy rpc%0d cyc%0d: got %b want %b", 1 << k, i,
                             busy_w[k], m_rem[k] != 0);
        end
        if (done_w[k] !== m_done[k]) begin
          errors++; $display("FAIL b2b done rpc%0d cyc%0d: got %b want %b", 1 << k, i,
                             done_w[k], m_done[k]);
        end
        if (sout_w[k] !== m_out[k]) begin
          errors++; $display("FAIL b2b state_out rpc%0d cyc%0d: got %h want %h", 1 << k, i,
                             sout_w[k], m_out[k]);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    start    = 1'b1;
    state_in = rand128();
    step();
    start = 1'b0;
    step();
    #3 rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      checks += 3;
      if (busy_w[k] !== 1'b0) begin
        errors++; $display("FAIL reset_mid busy rpc%0d: got %b want 0", 1 << k, busy_w[k]);
      end
      if (done_w[k] !== 1'b0) begin
        errors++; $display("FAIL reset_mid done rpc%0d: got %b want 0", 1 << k, done_w[k]);
      end
      if (sout_w[k] !== 128'h0) begin
        errors++; $display("FAIL reset_mid state_out rpc%0d: got %h want 0", 1 << k, sout_w[k]);
      end
    end
    #2 rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      start    = (i == 6);
      state_in = rand128();
      step();
      for (int k = 0; k < 3; k++) begin
        checks += 3;
        if (busy_w[k] !== (m_rem[k] != 0)) begin
          errors++; $display("FAIL reset_mid busy rpc%0d cyc%0d: got %b want %b", 1 << k, i,
                             busy_w[k], m_rem[k] != 0);
        end
        if (done_w[k] !== m_done[k]) begin
          errors++; $display("FAIL reset_mid done rpc%0d cyc%0d: got %b want %b", 1 << k, i,
                             done_w[k], m_done[k]);
        end
        if (sout_w[k] !== m_out[k]) begin
          errors++; $display("FAIL reset_mid state_out rpc%0d cyc%0d: got %h want %h", 1 << k, i,
                             sout_w[k], m_out[k]);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      start    = ($urandom_range(0, 2) == 0);
      state_in = rand128();
      step();
      for (int k = 0; k < 3; k++) begin
        checks += 3;
        if (busy_w[k] !== (m_rem[k] != 0)) begin
          errors++; $display("FAIL random busy rpc%0d cyc%0d: got %b want %b", 1 << k, i,
                             busy_w[k], m_rem[k] != 0);
        end
        if (done_w[k] !== m_done[k]) begin
          errors++; $display("FAIL random done rpc%0d cyc%0d: got %b want %b", 1 << k, i,
                             done_w[k], m_done[k]);
        end
        if (sout_w[k] !== m_out[k]) begin
          errors++; $display("FAIL random state_out rpc%0d cyc%0d: got %h want %h", 1 << k, i,
                             sout_w[k], m_out[k]);
        end
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    state_in = '0;
    model_reset();
    #12;
    test_reset();
    rst = 1'b0;
    test_fixed("vector", 128'h00010203_04050607_08090a0b_0c0d0e0f,
               128'h000d0a07_04010e0b_0805020f_0c090603);
    test_fixed("round_trip", 128'h00050a0f_04090e03_080d0207_0c01060b,
               128'h00010203_04050607_08090a0b_0c0d0e0f);
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
